// File: rtl/t20_pkg.sv
// Shared types, widths and helpers for the T20 match controller.
package t20_pkg;

  localparam int unsigned RUN_W            = 8;
  localparam int unsigned WKT_W            = 4;
  localparam int unsigned BALL_W           = 8;
  localparam int unsigned MAX_RUN_PER_BALL = 6;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INN1  = 3'd1,
    BREAK = 3'd2,
    INN2  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Delivery value above six (only 7 is possible) counts as six.
  function automatic logic [2:0] clamp_run(input logic [2:0] v);
    return (v > 3'(MAX_RUN_PER_BALL)) ? 3'(MAX_RUN_PER_BALL) : v;
  endfunction

endpackage

// File: rtl/innings_score_counter.sv
// Runs / wickets / legal-ball counters for one innings, all saturating.
module innings_score_counter
  import t20_pkg::*;
#(
  parameter int unsigned MAX_BALLS   = 120,
  parameter int unsigned MAX_WICKETS = 10,
  parameter int unsigned RUN_SAT     = 255
) (
  input  logic              clk_fpga,
  input  logic              rst,
  input  logic              en,
  input  logic              ev_run,
  input  logic              ev_extra,
  input  logic              ev_wicket,
  input  logic [2:0]        run_value,
  output logic [RUN_W-1:0]  runs,
  output logic [WKT_W-1:0]  wkts,
  output logic [BALL_W-1:0] balls,
  output logic [RUN_W-1:0]  runs_nx_c,
  output logic [WKT_W-1:0]  wkts_nx_c,
  output logic [BALL_W-1:0] balls_nx_c
);

  localparam int unsigned SUM_W = RUN_W + 1;

  logic [SUM_W-1:0] run_sum;

  // Post-event values; the top uses them for same-edge innings-end decisions.
  always_comb begin
    runs_nx_c  = runs;
    wkts_nx_c  = wkts;
    balls_nx_c = balls;
    run_sum    = '0;
    if (en) begin
      if (ev_wicket) begin
        if (wkts < WKT_W'(MAX_WICKETS)) wkts_nx_c = wkts + WKT_W'(1);
        if (balls < BALL_W'(MAX_BALLS)) balls_nx_c = balls + BALL_W'(1);
      end else if (ev_extra || ev_run) begin
        run_sum   = SUM_W'(runs) + SUM_W'(run_value) + SUM_W'(ev_extra);
        runs_nx_c = (run_sum > SUM_W'(RUN_SAT)) ? RUN_W'(RUN_SAT) : run_sum[RUN_W-1:0];
        if (ev_run && (balls < BALL_W'(MAX_BALLS))) balls_nx_c = balls + BALL_W'(1);
      end
    end
  end

  always_ff @(posedge clk_fpga) begin
    if (!rst) begin
      runs  <= '0;
      wkts  <= '0;
      balls <= '0;
    end else begin
      runs  <= runs_nx_c;
      wkts  <= wkts_nx_c;
      balls <= balls_nx_c;
    end
  end

endmodule

// File: rtl/t20_match_controller.sv
// T20 scoring sequencer: innings FSM, event priority decode and registered display mux.
module t20_match_controller
  import t20_pkg::*;
#(
  parameter int unsigned MAX_BALLS   = 120,
  parameter int unsigned MAX_WICKETS = 10,
  parameter int unsigned RUN_SAT     = 255
) (
  input  logic              clk_fpga,
  input  logic              rst,
  input  logic              start,
  input  logic              run_valid,
  input  logic [2:0]        run_value,
  input  logic              extra_valid,
  input  logic              wicket_valid,
  input  logic              view_sw,
  output logic [RUN_W-1:0]  binaryRuns,
  output logic [WKT_W-1:0]  wickets,
  output logic [BALL_W-1:0] ball_count,
  output logic              team_sw,
  output logic              ball_sw,
  output logic              inning_over,
  output logic              game_over,
  output logic              winner,
  output logic              tie
);

  state_t state, state_nx;

  logic              ev_wicket, ev_extra, ev_run, ev_any;
  logic [2:0]        run_clamp;
  logic              winner_d, tie_d, disp2_c;
  logic [RUN_W-1:0]  runs1, runs2, runs1_nx, runs2_nx;
  logic [WKT_W-1:0]  wkts1, wkts2, wkts1_nx, wkts2_nx;
  logic [BALL_W-1:0] balls1, balls2, balls1_nx, balls2_nx;

  // One event per cycle: wicket beats extra beats run.
  always_comb begin
    ev_wicket = wicket_valid;
    ev_extra  = extra_valid & ~wicket_valid;
    ev_run    = run_valid & ~extra_valid & ~wicket_valid;
    ev_any    = wicket_valid | extra_valid | run_valid;
    run_clamp = clamp_run(run_value);
  end

  innings_score_counter #(
    .MAX_BALLS(MAX_BALLS), .MAX_WICKETS(MAX_WICKETS), .RUN_SAT(RUN_SAT)
  ) u_inn1 (
    .clk_fpga(clk_fpga), .rst(rst), .en(state == INN1),
    .ev_run(ev_run), .ev_extra(ev_extra), .ev_wicket(ev_wicket), .run_value(run_clamp),
    .runs(runs1), .wkts(wkts1), .balls(balls1),
    .runs_nx_c(runs1_nx), .wkts_nx_c(wkts1_nx), .balls_nx_c(balls1_nx)
  );

  innings_score_counter #(
    .MAX_BALLS(MAX_BALLS), .MAX_WICKETS(MAX_WICKETS), .RUN_SAT(RUN_SAT)
  ) u_inn2 (
    .clk_fpga(clk_fpga), .rst(rst), .en(state == INN2),
    .ev_run(ev_run), .ev_extra(ev_extra), .ev_wicket(ev_wicket), .run_value(run_clamp),
    .runs(runs2), .wkts(wkts2), .balls(balls2),
    .runs_nx_c(runs2_nx), .wkts_nx_c(wkts2_nx), .balls_nx_c(balls2_nx)
  );

  always_ff @(posedge clk_fpga) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Chase is tested before the balls/wickets limit in innings 2.
  always_comb begin
    state_nx = state;
    winner_d = winner;
    tie_d    = tie;
    unique case (state)
      IDLE:  if (start) state_nx = INN1;
      INN1:  if (ev_any && ((balls1_nx == BALL_W'(MAX_BALLS)) ||
                            (wkts1_nx == WKT_W'(MAX_WICKETS)))) state_nx = BREAK;
      BREAK: if (start) state_nx = INN2;
      INN2: begin
        if (ev_any && ((runs2_nx > runs1_nx) ||
                       (balls2_nx == BALL_W'(MAX_BALLS)) ||
                       (wkts2_nx == WKT_W'(MAX_WICKETS)))) begin
          state_nx = DONE;
          winner_d = (runs2_nx > runs1_nx);
          tie_d    = (runs2_nx == runs1_nx);
        end
      end
      DONE:  state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  assign disp2_c = ((state == INN2) || (state == DONE)) ^ view_sw;

  always_ff @(posedge clk_fpga) begin
    if (!rst) begin
      binaryRuns  <= '0;
      wickets     <= '0;
      ball_count  <= '0;
      team_sw     <= 1'b0;
      ball_sw     <= 1'b0;
      inning_over <= 1'b0;
      game_over   <= 1'b0;
      winner      <= 1'b0;
      tie         <= 1'b0;
    end else begin
      binaryRuns  <= disp2_c ? runs2  : runs1;
      wickets     <= disp2_c ? wkts2  : wkts1;
      ball_count  <= disp2_c ? balls2 : balls1;
      team_sw     <= disp2_c;
      ball_sw     <= (state_nx == INN1) || (state_nx == INN2);
      inning_over <= (state_nx == BREAK);
      game_over   <= (state_nx == DONE);
      winner      <= winner_d;
      tie         <= tie_d;
    end
  end

endmodule

// File: doc/t20_match_controller.md
Name: t20_match_controller

Overview:
- Scoring sequencer for the T20 cricket scoreboard.
- Accepts single-cycle, already-debounced scoring event pulses and tracks runs, wickets and legal balls for both innings.
- Decides innings-over, match-over and the winner.
- Drives the scoreboard display control block: binaryRuns, wickets, ball_count, inning_over, game_over, winner, team_sw.

Parameters:
- MAX_BALLS, 120, legal balls per innings (20 overs x 6).
- MAX_WICKETS, 10, wickets that end an innings.
- RUN_SAT, 255, saturation value of the 8-bit run counters.

Ports:
- clk_fpga  input  1  100 MHz system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk_fpga.
- start  input  1  single-cycle pulse; begins innings 1 from IDLE or innings 2 from BREAK.
- run_valid  input  1  single-cycle pulse: legal delivery scored.
- run_value  input  3  runs on the delivery, 0..6; values 7 are treated as 6.
- extra_valid  input  1  single-cycle pulse: wide/no-ball; adds 1 + run_value runs, no legal ball.
- wicket_valid  input  1  single-cycle pulse: legal delivery, batter out, 0 runs.
- view_sw  input  1  0 shows the batting team's score; 1 shows the other innings' score.
- binaryRuns  output  8  runs of the displayed innings.
- wickets  output  4  wickets of the displayed innings.
- ball_count  output  8  legal balls of the displayed innings.
- team_sw  output  1  displayed team: 0 = team A (bats first), 1 = team B.
- ball_sw  output  1  high while state is INN1 or INN2 (display shows ball counter).
- inning_over  output  1  high in BREAK.
- game_over  output  1  high in DONE.
- winner  output  1  0 = team A, 1 = team B; valid only when game_over = 1 and tie = 0.
- tie  output  1  high in DONE when the two scores are equal.

Behaviour:
- State machine: IDLE -> INN1 -> BREAK -> INN2 -> DONE. DONE holds until reset.
- Reset (rst = 0 at a clock edge):
  - State goes to IDLE.
  - All run, wicket and ball counters go to 0.
  - All outputs go to 0.
  - Reset takes effect mid-innings or mid-event with no residue; an event pulse in the reset cycle is ignored.
- IDLE: start -> INN1. Scoring events are ignored.
- Event priority when several event pulses arrive in the same cycle: wicket_valid > extra_valid > run_valid. Exactly one event is applied per cycle; the rest are dropped.
- Events are accepted only in INN1/INN2. In IDLE, BREAK and DONE they are ignored and no counter changes.
- Event effects, all registered; counters update on the clock edge of the pulse and are visible 1 cycle later:
  - run: runs += min(run_value, 6); balls += 1.
  - extra: runs += 1 + min(run_value, 6); balls unchanged.
  - wicket: wickets += 1; balls += 1.
- Run arithmetic is 9-bit internally and saturates at RUN_SAT; it never wraps. Wickets saturate at MAX_WICKETS; balls saturate at MAX_BALLS.
- Innings 1 end: on the edge where balls reaches MAX_BALLS or wickets reaches MAX_WICKETS, state goes to BREAK.
  - inning_over is asserted 1 cycle after the terminating event.
  - start then moves BREAK -> INN2.
  - start in the same cycle as the terminating event is ignored.
- Innings 2 end, checked on the same edge as the counter update, using the post-update values:
  - Chase: runs2 > runs1 ends the innings immediately, even mid-over. The chase check is evaluated before the balls/wickets check.
  - Otherwise, balls = MAX_BALLS or wickets = MAX_WICKETS ends the innings.
  - State goes to DONE.
- DONE outcome:
  - winner = 1 if runs2 > runs1, else 0.
  - tie = 1 if runs2 == runs1.
  - winner and tie are registered on entry to DONE and are stable thereafter.
- Display mux, registered, 1-cycle latency:
  - Batting innings = 1 in INN1/BREAK/IDLE and 2 in INN2/DONE.
  - Displayed innings = batting innings XOR view_sw.
  - team_sw = displayed innings - 1.
  - binaryRuns, wickets and ball_count come from the displayed innings' counters.
- Outputs never glitch combinationally; all are flop outputs.

Decomposition:
- Shared package t20_pkg:
  - state encoding (IDLE, INN1, BREAK, INN2, DONE, 3-bit);
  - MAX_RUN_PER_BALL = 6;
  - widths RUN_W = 8, WKT_W = 4, BALL_W = 8.
- Natural sub-module: innings_score_counter, instantiated twice. It holds runs/wickets/balls with saturation and has an enable plus event-decode inputs.
- FSM, priority decode and display mux live in the top.

Test Plan:
- Reset mid-INN1 after 5 runs/2 balls -> next cycle all outputs 0, state IDLE; a run pulse in the reset cycle is not counted.
- start; 120 run pulses of value 1 -> ball_count = 120, binaryRuns = 120, inning_over = 1 exactly 1 cycle after the 120th pulse; a 121st pulse changes nothing.
- INN1: 10 wicket pulses -> wickets = 10, ball_count = 10, BREAK entered; extra pulses in BREAK ignored.
- Chase: runs1 = 30; in INN2, six 6s then a 1 -> DONE after the 6th pulse (36 > 30), winner = 1, tie = 0, game_over = 1; the trailing 1 is ignored.
- Tie: runs1 = 12; INN2 ends at 120 balls with runs2 = 12 -> tie = 1, game_over = 1; runs2 = 11 variant -> winner = 0, tie = 0.
- Same-cycle wicket + run(4) + extra -> only the wicket is applied (wickets += 1, balls += 1, runs unchanged). Extra with run_value = 7 adds 7 runs, balls unchanged. view_sw toggled in INN2 -> team_sw = 0 and innings-1 values 1 cycle later.
